// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use stall detection
// and branch-flush bubble insertion, driving the EX-stage ALU operands and op code.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_load,
  input  logic              id_store,
  input  logic              flush,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_load,
  output logic              ex_store,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall_id
);

  logic              ex_valid_r;
  logic [REG_AW-1:0] ex_rs_r;
  logic [REG_AW-1:0] ex_rt_r;
  logic [REG_AW-1:0] ex_rd_r;
  logic [DATA_W-1:0] ex_rs_data_r;
  logic [DATA_W-1:0] ex_rt_data_r;
  logic [DATA_W-1:0] ex_imm_r;
  logic              ex_alu_src_r;
  logic [2:0]        ex_alu_ctrl_r;
  logic              ex_reg_write_r;
  logic              ex_load_r;
  logic              ex_store_r;

  logic              stall_s;
  logic              bubble_s;
  logic [DATA_W-1:0] fwd_rs_s;
  logic [DATA_W-1:0] fwd_rt_s;
  logic [DATA_W-1:0] alu_a_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] store_data_s;

  // EX/MEM takes precedence over MEM/WB as it holds the younger write; r0 is hard-wired zero.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [REG_AW-1:0] reg_num,
    input logic [DATA_W-1:0] rf_data,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic [DATA_W-1:0] m_data,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] res;
    if (m_we && (m_rd != {REG_AW{1'b0}}) && (m_rd == reg_num)) begin
      res = m_data;
    end else if (w_we && (w_rd != {REG_AW{1'b0}}) && (w_rd == reg_num)) begin
      res = w_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Load-use detection; rt is always compared, even when the instruction uses the immediate.
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    if (id_valid && ex_valid_r && ex_load_r && (ex_rd_r != {REG_AW{1'b0}}) &&
        ((ex_rd_r == id_rs) || (ex_rd_r == id_rt))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    bubble_s = flush | stall_s;
  end

  // ID/EX capture register: flush and stall both load a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r     <= 1'b0;
      ex_rs_r        <= {REG_AW{1'b0}};
      ex_rt_r        <= {REG_AW{1'b0}};
      ex_rd_r        <= {REG_AW{1'b0}};
      ex_rs_data_r   <= {DATA_W{1'b0}};
      ex_rt_data_r   <= {DATA_W{1'b0}};
      ex_imm_r       <= {DATA_W{1'b0}};
      ex_alu_src_r   <= 1'b0;
      ex_alu_ctrl_r  <= 3'd0;
      ex_reg_write_r <= 1'b0;
      ex_load_r      <= 1'b0;
      ex_store_r     <= 1'b0;
    end else if (bubble_s) begin
      ex_valid_r     <= 1'b0;
      ex_rs_r        <= {REG_AW{1'b0}};
      ex_rt_r        <= {REG_AW{1'b0}};
      ex_rd_r        <= {REG_AW{1'b0}};
      ex_rs_data_r   <= {DATA_W{1'b0}};
      ex_rt_data_r   <= {DATA_W{1'b0}};
      ex_imm_r       <= {DATA_W{1'b0}};
      ex_alu_src_r   <= 1'b0;
      ex_alu_ctrl_r  <= 3'd0;
      ex_reg_write_r <= 1'b0;
      ex_load_r      <= 1'b0;
      ex_store_r     <= 1'b0;
    end else begin
      ex_valid_r     <= id_valid;
      ex_rs_r        <= id_rs;
      ex_rt_r        <= id_rt;
      ex_rd_r        <= id_rd;
      ex_rs_data_r   <= id_rs_data;
      ex_rt_data_r   <= id_rt_data;
      ex_imm_r       <= id_imm;
      ex_alu_src_r   <= id_alu_src;
      ex_alu_ctrl_r  <= id_alu_ctrl;
      ex_reg_write_r <= id_reg_write & id_valid;
      ex_load_r      <= id_load & id_valid;
      ex_store_r     <= id_store & id_valid;
    end
  end

  // Operand forwarding and B-mux; operands read zero in a bubble so the ALU Zero flag is set.
  always_comb begin
    fwd_rs_s     = fwd_operand(ex_rs_r, ex_rs_data_r, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                               wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    fwd_rt_s     = fwd_operand(ex_rt_r, ex_rt_data_r, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                               wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    alu_a_s      = {DATA_W{1'b0}};
    alu_b_s      = {DATA_W{1'b0}};
    store_data_s = {DATA_W{1'b0}};
    if (ex_valid_r) begin
      alu_a_s      = fwd_rs_s;
      alu_b_s      = ex_alu_src_r ? ex_imm_r : fwd_rt_s;
      store_data_s = fwd_rt_s;
    end else begin
      alu_a_s      = {DATA_W{1'b0}};
      alu_b_s      = {DATA_W{1'b0}};
      store_data_s = {DATA_W{1'b0}};
    end
  end

  assign alu_a         = alu_a_s;
  assign alu_b         = alu_b_s;
  assign ex_store_data = store_data_s;
  assign alu_ctrl      = ex_alu_ctrl_r;
  assign ex_valid      = ex_valid_r;
  assign ex_rd         = ex_rd_r;
  assign ex_reg_write  = ex_reg_write_r;
  assign ex_load       = ex_load_r;
  assign ex_store      = ex_store_r;
  assign stall_id      = stall_s;

endmodule
